board_ram_arbiter: RTL and testbench



---
 rtl/board_ram_arbiter.sv | 80 ++++++++
 tb/tb_board_ram_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: round-robin, burst-locked sharing of the single-port board RAM with tagged read return
module board_ram_arbiter #(
    parameter int NREQ   = 4,
    parameter int DEPTH  = 200,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [8*NREQ-1:0] addr_bus,
    input  logic [6*NREQ-1:0] wdata_bus,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [5:0]        rdata,
    output logic [7:0]        ram_addr,
    output logic              ram_wren,
    output logic [5:0]        ram_data,
    input  logic [5:0]        ram_q
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic {IDLE, OWNED} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] last, last_nxt, pick;
    logic [NREQ-1:0] gnt_nxt;
    logic acc, oor;
    logic [7:0] a_addr;
    logic [5:0] a_data;
    logic [RD_LAT-1:0] p_v, p_o;
    logic [IW-1:0] p_id [RD_LAT];
    always_comb begin
        pick = last;
        for (int k = NREQ; k >= 1; k--)
            if (req[IW'((int'(last) + k) % NREQ)]) pick = IW'((int'(last) + k) % NREQ);
    end
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        if (!(state == OWNED && req[last])) begin
            state_nxt = |req ? OWNED : IDLE;
            gnt_nxt   = |req ? NREQ'(1) << pick : '0;
            last_nxt  = |req ? pick : last;
        end
    end
    // while granted, last always names the owner
    always_comb begin
        a_addr   = addr_bus[8*last +: 8];
        a_data   = wdata_bus[6*last +: 6];
        acc      = |(gnt & req);
        oor      = int'(a_addr) >= DEPTH;
        ram_addr = acc ? a_addr : '0;
        ram_data = acc ? a_data : '0;
        ram_wren = acc & we[last] & ~oor;
        rvalid   = p_v[RD_LAT-1] ? NREQ'(1) << p_id[RD_LAT-1] : '0;
        rdata    = (p_v[RD_LAT-1] & ~p_o[RD_LAT-1]) ? ram_q : '0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= IW'(NREQ - 1);
            p_v   <= '0;
            p_o   <= '0;
            for (int i = 0; i < RD_LAT; i++) p_id[i] <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            last    <= last_nxt;
            p_v[0]  <= acc & ~we[last];
            p_o[0]  <= oor;
            p_id[0] <= last;
            for (int i = 1; i < RD_LAT; i++) begin
                p_v[i]  <= p_v[i-1];
                p_o[i]  <= p_o[i-1];
                p_id[i] <= p_id[i-1];
            end
        end
    end
endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb_board_ram_arbiter: directed bench with a cycle-level behavioural model, RD_LAT=1 and RD_LAT=2 instances
module tb_board_ram_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    logic [3:0] req, we;
    logic [31:0] addr_bus;
    logic [23:0] wdata_bus;
    logic [3:0] gnt1, gnt2, rvalid1, rvalid2;
    logic [5:0] rdata1, rdata2, ram_data1, ram_data2, ram_q1, ram_q2, q2a;
    logic [7:0] ram_addr1, ram_addr2;
    logic ram_wren1, ram_wren2;
    logic [5:0] mem1 [256];
    logic [5:0] mem2 [256];
    logic [5:0] gmem [256];
    logic [3:0] s_rv [2][8];
    logic [5:0] s_rd [2][8];
    logic [3:0] exp_tr [14] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8, 4'h0};
    int passed = 0, total = 0, cyc = 0, m_own, m_last, o, slot;
    int cnt [4];
    logic acc, e_wren;
    logic [3:0] e_gnt;
    logic [7:0] e_addr;
    logic [5:0] e_data;

    always #5 clk = ~clk;

    board_ram_arbiter #(.RD_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr_bus(addr_bus), .wdata_bus(wdata_bus),
        .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1), .ram_addr(ram_addr1), .ram_wren(ram_wren1),
        .ram_data(ram_data1), .ram_q(ram_q1));
    board_ram_arbiter #(.RD_LAT(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr_bus(addr_bus), .wdata_bus(wdata_bus),
        .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2), .ram_addr(ram_addr2), .ram_wren(ram_wren2),
        .ram_data(ram_data2), .ram_q(ram_q2));

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", n, got, exp);
        else passed++;
    endtask
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask
    task automatic mid();
        @(negedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset_n = 1'b0;
        req = '0;
        we = '0;
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    // board RAMs with one and two cycles of read latency, preloaded with a pattern
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] <= 6'(i) ^ 6'h15;
            mem2[i] <= 6'(i) ^ 6'h15;
        end
        ram_q1 <= '0;
        ram_q2 <= '0;
        q2a <= '0;
        forever begin
            @(posedge clk);
            ram_q1 <= mem1[ram_addr1];
            q2a <= mem2[ram_addr2];
            ram_q2 <= q2a;
            if (ram_wren1) mem1[ram_addr1] <= ram_data1;
            if (ram_wren2) mem2[ram_addr2] <= ram_data2;
        end
    end

    // model: owner index, round-robin pointer, golden memory and per-cycle read-return schedule
    initial begin
        for (int i = 0; i < 256; i++) gmem[i] = 6'(i) ^ 6'h15;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_own = -1;
                m_last = 3;
                for (int l = 0; l < 2; l++)
                    for (int s = 0; s < 8; s++) begin
                        s_rv[l][s] = '0;
                        s_rd[l][s] = '0;
                    end
                chk("rst_gnt", {gnt2, gnt1}, 0);
                chk("rst_rvalid", {rvalid2, rvalid1}, 0);
                chk("rst_ram", {ram_wren2, ram_wren1, ram_addr2, ram_addr1, ram_data2, ram_data1}, 0);
                chk("rst_rdata", {rdata2, rdata1}, 0);
            end else begin
                o = m_own < 0 ? 0 : m_own;
                acc = m_own >= 0 && req[o];
                e_gnt = m_own < 0 ? 4'b0 : 4'(1 << o);
                e_addr = acc ? addr_bus[8*o +: 8] : 8'd0;
                e_data = acc ? wdata_bus[6*o +: 6] : 6'd0;
                e_wren = acc && we[o] && e_addr < 8'd200;
                chk("gnt_lat1", gnt1, e_gnt);
                chk("gnt_lat2", gnt2, e_gnt);
                chk("ram_addr", {ram_addr2, ram_addr1}, {e_addr, e_addr});
                chk("ram_data", {ram_data2, ram_data1}, {e_data, e_data});
                chk("ram_wren", {ram_wren2, ram_wren1}, {e_wren, e_wren});
                slot = cyc % 8;
                chk("rvalid_lat1", rvalid1, s_rv[0][slot]);
                chk("rvalid_lat2", rvalid2, s_rv[1][slot]);
                if (s_rv[0][slot] != 0) chk("rdata_lat1", rdata1, s_rd[0][slot]);
                if (s_rv[1][slot] != 0) chk("rdata_lat2", rdata2, s_rd[1][slot]);
                for (int l = 0; l < 2; l++) s_rv[l][slot] = '0;
                if (acc && !we[o])
                    for (int l = 0; l < 2; l++) begin
                        s_rv[l][(cyc + l + 1) % 8] = 4'(1 << o);
                        s_rd[l][(cyc + l + 1) % 8] = e_addr < 8'd200 ? gmem[e_addr] : 6'd0;
                    end
                if (e_wren) gmem[e_addr] = e_data;
                if (!acc) begin
                    m_own = -1;
                    for (int k = 1; k <= 4; k++)
                        if (m_own < 0 && req[(m_last + k) % 4]) m_own = (m_last + k) % 4;
                    if (m_own >= 0) m_last = m_own;
                end
            end
            cyc++;
        end
    end

    initial begin
        reset_n = 1'b1;
        req = '0;
        we = '0;
        addr_bus = '0;
        wdata_bus = '0;
        #2;
        do_reset();
        // single read from requester 0
        req = 4'b0001;
        addr_bus[7:0] = 8'd15;
        mid();
        chk("t1_no_same_cycle_gnt", gnt1, 4'b0000);
        cycle();
        mid();
        chk("t1_gnt", gnt1, 4'b0001);
        chk("t1_ram_addr", ram_addr1, 8'd15);
        cycle();
        req = 4'b0000;
        mid();
        chk("t1_rvalid1", rvalid1, 4'b0001);
        chk("t1_rdata1", rdata1, 6'h1A);
        chk("t1_rvalid2_early", rvalid2, 4'b0000);
        cycle();
        mid();
        chk("t1_rvalid2", rvalid2, 4'b0001);
        chk("t1_rdata2", rdata2, 6'h1A);
        // all four request, each drops after two accesses
        do_reset();
        req = 4'b1111;
        addr_bus = {8'd40, 8'd30, 8'd20, 8'd10};
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 14; c++) begin
            mid();
            chk($sformatf("rr_gnt_c%0d", c), gnt1, exp_tr[c]);
            for (int i = 0; i < 4; i++) if (gnt1[i] && req[i]) cnt[i]++;
            cycle();
            for (int i = 0; i < 4; i++) if (cnt[i] == 2) req[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) chk($sformatf("rr_accesses_%0d", i), 32'(cnt[i]), 2);
        // requester 1: write, read back, out-of-range write and read
        req = 4'b0010;
        we = 4'b0010;
        addr_bus[15:8] = 8'd199;
        wdata_bus[11:6] = 6'h2A;
        cycle();
        mid();
        chk("t3_wren", ram_wren1, 1'b1);
        chk("t3_waddr", ram_addr1, 8'd199);
        chk("t3_wdata", ram_data1, 6'h2A);
        cycle();
        we = 4'b0000;
        cycle();
        we = 4'b0010;
        addr_bus[15:8] = 8'd200;
        wdata_bus[11:6] = 6'h3F;
        mid();
        chk("t3_rvalid1", rvalid1, 4'b0010);
        chk("t3_rdata1", rdata1, 6'h2A);
        chk("t4_oor_wren", ram_wren1, 1'b0);
        cycle();
        we = 4'b0000;
        addr_bus[15:8] = 8'd250;
        mid();
        chk("t3_rvalid2", rvalid2, 4'b0010);
        chk("t3_rdata2", rdata2, 6'h2A);
        cycle();
        req = 4'b0000;
        mid();
        chk("t4_oor_rvalid1", rvalid1, 4'b0010);
        chk("t4_oor_rdata1", rdata1, 6'h00);
        cycle();
        mid();
        chk("t4_oor_rvalid2", rvalid2, 4'b0010);
        chk("t4_oor_rdata2", rdata2, 6'h00);
        // owner 2 reads then leaves while requester 3 waits
        cycle();
        req = 4'b0100;
        addr_bus[23:16] = 8'd15;
        cycle();
        req = 4'b1100;
        addr_bus[31:24] = 8'd20;
        cycle();
        req = 4'b1000;
        mid();
        chk("t5_gnt_held", gnt1, 4'b0100);
        cycle();
        mid();
        chk("t5_gnt_switch", gnt2, 4'b1000);
        chk("t5_rvalid_tag", rvalid2, 4'b0100);
        chk("t5_rdata", rdata2, 6'h1A);
        cycle();
        req = 4'b0000;
        cycle();
        cycle();
        // reset pulse with a read in flight
        req = 4'b1111;
        addr_bus = {8'd3, 8'd2, 8'd1, 8'd0};
        cycle();
        cycle();
        chk("t6_pre_reset_rvalid", rvalid1, 4'b0001);
        reset_n = 1'b0;
        #1;
        chk("t6_async_gnt", {gnt2, gnt1}, 0);
        chk("t6_async_rvalid", {rvalid2, rvalid1}, 0);
        chk("t6_async_wren", {ram_wren2, ram_wren1}, 0);
        cycle();
        cycle();
        reset_n = 1'b1;
        mid();
        chk("t6_no_rvalid_after", {rvalid2, rvalid1}, 0);
        chk("t6_gnt_release", gnt1, 4'b0000);
        cycle();
        mid();
        chk("t6_first_gnt", gnt1, 4'b0001);
        cycle();
        req = 4'b0000;
        cycle();
        cycle();
        cycle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
